wbu: RTL and testbench
======================

WBU -- requirements
Module: wbu

Interface
REQ-001 SHALL have parameter WIDTH, default 32: datapath and register width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port lsu_valid  input  1  upstream LSU result valid.
REQ-005 SHALL have port lsu_data  input  104  upstream LSU result payload.
REQ-006 SHALL decode lsu_data as follows:
- [103:72] alu_result
- [71:40] load_data
- [39:8] next_pc
- [7:3] rd
- [2] rf_wen
- [1] load_sel
- [0] halt_req
REQ-007 SHALL have port wbu_ready  output  1  WBU can accept a result.
REQ-008 SHALL have port wbu_valid  output  1  commit done, wbu_npc valid for IFU.
REQ-009 SHALL have port wbu_npc  output  32  next fetch address.
REQ-010 SHALL have port ifu_ready  input  1  IFU accepts wbu_npc.
REQ-011 SHALL have port rs1_addr  input  5  IDU read port 1 index.
REQ-012 SHALL have port rs1_data  output  32  combinational read data for rs1_addr.
REQ-013 SHALL have port rs2_addr  input  5  IDU read port 2 index.
REQ-014 SHALL have port rs2_data  output  32  combinational read data for rs2_addr.
REQ-015 SHALL have port halted  output  1  halt instruction committed.

Function
REQ-016 SHALL own a 32 x 32-bit register file; x0 reads 0 and ignores writes.
REQ-017 SHALL implement states S_IDLE, S_WRITE, S_WAIT_IFU, S_HALT.
REQ-018 SHALL drive wbu_ready=1 only in S_IDLE.
REQ-019 SHALL, in S_IDLE, latch lsu_data and go to S_WRITE on a clk edge where lsu_valid & wbu_ready; otherwise stay in S_IDLE.
REQ-020 SHALL select write data = load_sel ? load_data : alu_result.
REQ-021 SHALL, at the S_WRITE exit edge, write the selected data to rf[rd] if rf_wen and rd != 0, and load wbu_npc <= next_pc.
REQ-022 SHALL leave S_WRITE after one cycle: to S_HALT if halt_req, else to S_WAIT_IFU.
REQ-023 SHALL drive wbu_valid=1 only in S_WAIT_IFU; S_WAIT_IFU -> S_IDLE on an edge with ifu_ready=1, otherwise hold, with wbu_npc stable.
REQ-024 SHALL give latency: accept at edge E0; rf updated and wbu_valid asserted after E1; earliest next accept at edge E2+1, with ifu_ready=1 during the first S_WAIT_IFU cycle.
REQ-025 SHALL return rs1_data/rs2_data values written at E1 from the cycle after E1; there is no same-cycle bypass.
REQ-026 SHALL keep S_HALT until reset, with halted=1, wbu_ready=0, wbu_valid=0, and ignore lsu_valid; the halt instruction's rf write still occurs.
REQ-027 SHALL ignore lsu_data changes while not in S_IDLE; the latched copy alone is used.
REQ-028 SHALL ignore ifu_ready outside S_WAIT_IFU.

Reset
REQ-029 SHALL, on rst=1 at a clk edge, go to S_IDLE from any state, including mid-S_WRITE; any pending rf write is discarded.
REQ-030 SHALL reset all rf entries to 0, wbu_npc to 32'h8000_0000, halted to 0, and the latched payload to 0.
REQ-031 SHALL drive outputs during and right after reset as: wbu_ready=1, wbu_valid=0, halted=0.

Configuration
REQ-032 SHALL, with macro WBU_COMMIT_CNT_EN defined, add output commit_cnt (64 bits), reset 0, incremented by 1 at each S_WRITE exit edge, the halt instruction included, wrapping at 2^64.
REQ-033 SHALL, without WBU_COMMIT_CNT_EN, have no commit_cnt port and no counter logic; all other behaviour is identical.

Verification
REQ-034 SHALL cover ALU writeback: rd=5, rf_wen=1, load_sel=0, alu_result=32'h1234_5678, next_pc=32'h8000_0004, ifu_ready=1 -> rs1_addr=5 reads 32'h1234_5678 after E1; wbu_valid=1 for 1 cycle with wbu_npc=32'h8000_0004.
REQ-035 SHALL cover load select and x0: load_sel=1, load_data=32'hFFFF_FF80, rd=0 -> rf[0] reads 0; same payload with rd=7 -> rf[7]=32'hFFFF_FF80.
REQ-036 SHALL cover IFU backpressure: ifu_ready=0 for 5 cycles -> wbu_valid held 5 cycles, wbu_npc stable, wbu_ready=0, a new lsu_valid not accepted; ifu_ready=1 -> S_IDLE next cycle.
REQ-037 SHALL cover halt: halt_req=1, rd=10, alu_result=0 -> rf[10]=0, halted=1 after E1, wbu_valid never asserted, further lsu_valid ignored for 20 cycles.
REQ-038 SHALL cover reset mid-operation: rst=1 during S_WRITE -> no rf write, wbu_ready=1, wbu_npc=32'h8000_0000, and with WBU_COMMIT_CNT_EN, commit_cnt=0.
REQ-039 SHALL cover back-to-back: 3 commits with ifu_ready=1 -> each accepted 3 cycles apart; with WBU_COMMIT_CNT_EN, commit_cnt=3.

Source files
------------

// File: rtl/wbu.sv
// wbu -- writeback unit.
// Accepts one LSU result at a time and latches it. The following cycle it
// commits the result to the 32 x WIDTH register file and loads the next
// fetch address. It then offers that address to the IFU and holds it until
// the IFU takes it. A committed halt parks the unit until reset.
// Optional feature: define WBU_COMMIT_CNT_EN to add a 64-bit commit_cnt
// output that counts every commit, including the halt instruction.
module wbu #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lsu_valid,
  input  logic [3*WIDTH+7:0]   lsu_data,
  output logic                 wbu_ready,
  output logic                 wbu_valid,
  output logic [WIDTH-1:0]     wbu_npc,
  input  logic                 ifu_ready,
  input  logic [4:0]           rs1_addr,
  output logic [WIDTH-1:0]     rs1_data,
  input  logic [4:0]           rs2_addr,
  output logic [WIDTH-1:0]     rs2_data,
  output logic                 halted
`ifdef WBU_COMMIT_CNT_EN
  ,
  output logic [63:0]          commit_cnt
`endif
);

  localparam int               PW       = 3*WIDTH + 8;
  localparam logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h8000_0000);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_WAIT_IFU,
    S_HALT
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [PW-1:0]    payload_reg;
  logic [WIDTH-1:0] npc_reg;

  // x0 is not stored; reads of index 0 are forced to zero below.
  logic [WIDTH-1:0] rf_reg [1:31];

  // Fields of the latched payload.
  logic [WIDTH-1:0] pl_alu_result;
  logic [WIDTH-1:0] pl_load_data;
  logic [WIDTH-1:0] pl_next_pc;
  logic [4:0]       pl_rd;
  logic             pl_rf_wen;
  logic             pl_load_sel;
  logic             pl_halt_req;

  assign pl_alu_result = payload_reg[3*WIDTH+7 -: WIDTH];
  assign pl_load_data  = payload_reg[2*WIDTH+7 -: WIDTH];
  assign pl_next_pc    = payload_reg[WIDTH+7 -: WIDTH];
  assign pl_rd         = payload_reg[7:3];
  assign pl_rf_wen     = payload_reg[2];
  assign pl_load_sel   = payload_reg[1];
  assign pl_halt_req   = payload_reg[0];

  logic             accept;
  logic             commit;
  logic             rf_we;
  logic [WIDTH-1:0] wr_data;

  // Leaving S_WRITE is the commit point; reset takes priority in every
  // register, so a commit cut short by reset is dropped.
  assign accept  = (state_reg == S_IDLE) && lsu_valid;
  assign commit  = (state_reg == S_WRITE);
  assign rf_we   = commit && pl_rf_wen && (pl_rd != 5'd0);
  assign wr_data = pl_load_sel ? pl_load_data : pl_alu_result;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_next = state_reg;
    wbu_ready  = 1'b0;
    wbu_valid  = 1'b0;
    halted     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        wbu_ready = 1'b1;
        if (lsu_valid) state_next = S_WRITE;
      end
      S_WRITE: begin
        state_next = pl_halt_req ? S_HALT : S_WAIT_IFU;
      end
      S_WAIT_IFU: begin
        wbu_valid = 1'b1;
        if (ifu_ready) state_next = S_IDLE;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Capture the payload only on acceptance; later lsu_data changes are ignored.
  always_ff @(posedge clk) begin
    if (rst)         payload_reg <= '0;
    else if (accept) payload_reg <= lsu_data;
  end

  // Next fetch address, loaded at the commit edge and held until the next one.
  always_ff @(posedge clk) begin
    if (rst)         npc_reg <= RESET_PC;
    else if (commit) npc_reg <= pl_next_pc;
  end

  assign wbu_npc = npc_reg;

  // Register file entries x1..x31. Each entry is a resettable register, so
  // reset clears the whole file in one cycle.
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_rf
      // Entry gi takes the committed data when it is the destination.
      always_ff @(posedge clk) begin
        if (rst)                              rf_reg[gi] <= '0;
        else if (rf_we && (pl_rd == 5'(gi)))  rf_reg[gi] <= wr_data;
      end
    end
  endgenerate

  // Combinational read ports with no write bypass; index 0 reads zero.
  assign rs1_data = (rs1_addr == 5'd0) ? '0 : rf_reg[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? '0 : rf_reg[rs2_addr];

`ifdef WBU_COMMIT_CNT_EN
  logic [63:0] commit_cnt_reg;

  // Count every commit edge, including the halt instruction; wraps at 2^64.
  always_ff @(posedge clk) begin
    if (rst)         commit_cnt_reg <= '0;
    else if (commit) commit_cnt_reg <= commit_cnt_reg + 64'd1;
  end

  assign commit_cnt = commit_cnt_reg;
`endif

endmodule

// File: tb/tb_wbu.sv
// tb_wbu -- self-checking bench for wbu.
// The bench keeps a scoreboard of expected commits (next PC, destination,
// expected register value). Entries are pushed when a result is driven and
// popped when wbu_valid shows the commit. Define WBU_COMMIT_CNT_EN for both
// the bench and the design to exercise the commit counter.
module tb_wbu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         rst;
  logic         lsu_valid;
  logic [103:0] lsu_data;
  logic         wbu_ready;
  logic         wbu_valid;
  logic [31:0]  wbu_npc;
  logic         ifu_ready;
  logic [4:0]   rs1_addr;
  logic [31:0]  rs1_data;
  logic [4:0]   rs2_addr;
  logic [31:0]  rs2_data;
  logic         halted;
`ifdef WBU_COMMIT_CNT_EN
  logic [63:0]  commit_cnt;
`endif

  always #5 clk = ~clk;

  wbu #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .lsu_valid (lsu_valid),
    .lsu_data  (lsu_data),
    .wbu_ready (wbu_ready),
    .wbu_valid (wbu_valid),
    .wbu_npc   (wbu_npc),
    .ifu_ready (ifu_ready),
    .rs1_addr  (rs1_addr),
    .rs1_data  (rs1_data),
    .rs2_addr  (rs2_addr),
    .rs2_data  (rs2_data),
    .halted    (halted)
`ifdef WBU_COMMIT_CNT_EN
    ,
    .commit_cnt(commit_cnt)
`endif
  );

  typedef struct packed {
    logic [31:0] npc;
    logic [4:0]  rd;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl_rf [32];
  logic [63:0] mdl_cnt;
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic logic [103:0] mk(input logic [31:0] alu, input logic [31:0] ld,
                                      input logic [31:0] npc, input logic [4:0] rd,
                                      input logic wen, input logic sel, input logic hlt);
    return {alu, ld, npc, rd, wen, sel, hlt};
  endfunction

  // Reference model: update the expected register file and queue the commit.
  task automatic push_exp(input logic [103:0] p);
    logic [4:0]  rd;
    logic [31:0] d;
    exp_t        e;
    rd = p[7:3];
    d  = p[1] ? p[71:40] : p[103:72];
    if (p[2] && rd != 5'd0) mdl_rf[rd] = d;
    mdl_cnt = mdl_cnt + 64'd1;
    if (!p[0]) begin
      e.npc = p[39:8];
      e.rd  = rd;
      e.val = mdl_rf[rd];
      sb.push_back(e);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    lsu_valid = 1'b0;
    ifu_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    for (int i = 0; i < 32; i++) mdl_rf[i] = '0;
    mdl_cnt = '0;
  endtask

  // Offer one result at the first negedge where wbu_ready is high. Returns at
  // the negedge after the accepting edge, with lsu_data scrambled to show the
  // latched copy is what gets committed.
  task automatic send(input logic [103:0] p, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (wbu_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) return;
    lsu_valid = 1'b1;
    lsu_data  = p;
    push_exp(p);
    @(negedge clk);
    lsu_valid = 1'b0;
    lsu_data  = {$urandom, $urandom, $urandom, 8'($urandom)};
  endtask

  task automatic wait_valid(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (wbu_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; lsu_valid = 1'b0; lsu_data = '0; ifu_ready = 1'b0;
    rs1_addr = '0; rs2_addr = '0;
    @(negedge clk);
    n_tests++;
    if ({wbu_ready, wbu_valid, halted} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_during: ready/valid/halted got %b want 100", {wbu_ready, wbu_valid, halted});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({wbu_ready, wbu_valid, halted} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_after: ready/valid/halted got %b want 100", {wbu_ready, wbu_valid, halted});
    end
    n_tests++;
    if (wbu_npc !== RESET_PC) begin
      n_fail++;
      $display("FAIL reset_npc: got %h want %h", wbu_npc, RESET_PC);
    end
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(31 - i);
      #1;
      n_tests++;
      if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_rf[%0d]: rs1 %h rs2 %h want 0", i, rs1_data, rs2_data);
      end
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_alu_wb();
    bit   ok;
    exp_t e;
    do_reset();
    ifu_ready = 1'b1;
    send(mk(32'h1234_5678, 32'hCAFE_0000, 32'h8000_0004, 5'd5, 1'b1, 1'b0, 1'b0), ok);
    rs1_addr = 5'd5;
    #1;
    n_tests++;
    if (!ok || wbu_ready !== 1'b0 || wbu_valid !== 1'b0 || rs1_data !== 32'h0) begin
      n_fail++;
      $display("FAIL alu_in_write: ok %0d ready %b valid %b rf5 %h want 1 0 0 00000000", ok, wbu_ready, wbu_valid, rs1_data);
    end
    wait_valid(5, ok);
    n_tests++;
    if (!ok || sb.size() == 0) begin
      n_fail++;
      $display("FAIL alu_commit: valid seen %0d, pending %0d, want 1 and 1", ok, sb.size());
      return;
    end
    e = sb.pop_front();
    rs1_addr = e.rd;
    #1;
    n_tests++;
    if (wbu_npc !== e.npc || rs1_data !== e.val) begin
      n_fail++;
      $display("FAIL alu_data: npc %h rf %h want %h %h", wbu_npc, rs1_data, e.npc, e.val);
    end
    $display("[TB] commit rd=%0d data=%h npc=%h", e.rd, rs1_data, wbu_npc);
    @(negedge clk);
    n_tests++;
    if (wbu_valid !== 1'b0 || wbu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL alu_valid_1cyc: valid %b ready %b want 0 1", wbu_valid, wbu_ready);
    end
  endtask

  task automatic test_load_x0();
    bit   ok;
    exp_t e;
    do_reset();
    ifu_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      send(mk(32'h0BAD_0BAD, 32'hFFFF_FF80, 32'h8000_0008 + 32'(4*k), (k == 0) ? 5'd0 : 5'd7,
              1'b1, 1'b1, 1'b0), ok);
      wait_valid(5, ok);
      n_tests++;
      if (!ok || sb.size() == 0) begin
        n_fail++;
        $display("FAIL load_commit%0d: valid seen %0d, pending %0d", k, ok, sb.size());
        return;
      end
      e = sb.pop_front();
      rs2_addr = e.rd;
      #1;
      n_tests++;
      if (wbu_npc !== e.npc || rs2_data !== e.val) begin
        n_fail++;
        $display("FAIL load_rd%0d: npc %h rf %h want %h %h", e.rd, wbu_npc, rs2_data, e.npc, e.val);
      end
      $display("[TB] commit rd=%0d data=%h npc=%h", e.rd, rs2_data, wbu_npc);
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    bit   ok;
    exp_t e;
    do_reset();
    send(mk(32'hA5A5_A5A5, 32'h0, 32'h8000_0010, 5'd3, 1'b1, 1'b0, 1'b0), ok);
    wait_valid(5, ok);
    n_tests++;
    if (!ok || sb.size() == 0) begin
      n_fail++;
      $display("FAIL bp_commit: valid seen %0d, pending %0d", ok, sb.size());
      return;
    end
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (wbu_valid !== 1'b1 || wbu_ready !== 1'b0 || wbu_npc !== e.npc) begin
        n_fail++;
        $display("FAIL bp_hold%0d: valid %b ready %b npc %h want 1 0 %h", i, wbu_valid, wbu_ready, wbu_npc, e.npc);
      end
      lsu_valid = (i != 4);
      lsu_data  = mk(32'h9999_9999, 32'h0, 32'h8000_0F00, 5'd9, 1'b1, 1'b0, 1'b0);
      if (i == 4) ifu_ready = 1'b1;
      @(negedge clk);
    end
    rs1_addr = e.rd;
    rs2_addr = 5'd9;
    #1;
    n_tests++;
    if (wbu_valid !== 1'b0 || wbu_ready !== 1'b1 || rs1_data !== e.val || rs2_data !== mdl_rf[9]) begin
      n_fail++;
      $display("FAIL bp_release: valid %b ready %b rf3 %h rf9 %h want 0 1 %h %h",
               wbu_valid, wbu_ready, rs1_data, rs2_data, e.val, mdl_rf[9]);
    end
    $display("[TB] commit rd=%0d data=%h npc=%h after backpressure", e.rd, rs1_data, e.npc);
  endtask

  task automatic test_back_to_back();
    logic [103:0] p [3];
    int           acc_cyc [3];
    int           k;
    int           seen;
    exp_t         e;
    do_reset();
    ifu_ready = 1'b1;
    p[0] = mk(32'h1111_0001, 32'h0,         32'h8000_0020, 5'd1, 1'b1, 1'b0, 1'b0);
    p[1] = mk(32'h0,         32'h2222_0002, 32'h8000_0024, 5'd2, 1'b1, 1'b1, 1'b0);
    p[2] = mk(32'h3333_0003, 32'h0,         32'h8000_0028, 5'd1, 1'b1, 1'b0, 1'b0);
    k = 0;
    seen = 0;
    for (int cyc = 0; cyc < 40 && seen < 3; cyc++) begin
      if (wbu_valid) begin
        if (sb.size() != 0) begin
          e = sb.pop_front();
          rs1_addr = e.rd;
          #1;
          n_tests++;
          if (wbu_npc !== e.npc || rs1_data !== e.val) begin
            n_fail++;
            $display("FAIL b2b_commit%0d: npc %h rf %h want %h %h", seen, wbu_npc, rs1_data, e.npc, e.val);
          end
          $display("[TB] commit rd=%0d data=%h npc=%h", e.rd, rs1_data, wbu_npc);
        end
        seen++;
      end
      if (wbu_ready) begin
        if (k < 3) begin
          lsu_valid  = 1'b1;
          lsu_data   = p[k];
          push_exp(p[k]);
          acc_cyc[k] = cyc;
          k++;
        end else begin
          lsu_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    lsu_valid = 1'b0;
    n_tests++;
    if (seen != 3 || k != 3) begin
      n_fail++;
      $display("FAIL b2b_count: commits %0d accepts %0d want 3 3", seen, k);
      return;
    end
    n_tests++;
    if (acc_cyc[1] - acc_cyc[0] != 3 || acc_cyc[2] - acc_cyc[1] != 3) begin
      n_fail++;
      $display("FAIL b2b_spacing: gaps %0d %0d want 3 3", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
    end
`ifdef WBU_COMMIT_CNT_EN
    n_tests++;
    if (commit_cnt !== mdl_cnt) begin
      n_fail++;
      $display("FAIL b2b_commit_cnt: got %0d want %0d", commit_cnt, mdl_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid();
    bit   ok;
    exp_t e;
    do_reset();
    ifu_ready = 1'b1;
    send(mk(32'h0000_0C0C, 32'h0, 32'h8000_0100, 5'd12, 1'b1, 1'b0, 1'b0), ok);
    wait_valid(5, ok);
    n_tests++;
    if (!ok || sb.size() == 0) begin
      n_fail++;
      $display("FAIL rstmid_first: valid seen %0d, pending %0d", ok, sb.size());
      return;
    end
    e = sb.pop_front();
    $display("[TB] commit rd=%0d npc=%h before mid-write reset", e.rd, wbu_npc);
    @(negedge clk);
    send(mk(32'h0000_0D0D, 32'h0, 32'h8000_0200, 5'd13, 1'b1, 1'b0, 1'b0), ok);
    n_tests++;
    if (!ok || wbu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_in_write: ok %0d ready %b want 1 0", ok, wbu_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    rs1_addr = 5'd13;
    rs2_addr = 5'd12;
    #1;
    n_tests++;
    if (wbu_ready !== 1'b1 || wbu_valid !== 1'b0 || wbu_npc !== RESET_PC ||
        rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid_state: ready %b valid %b npc %h rf13 %h rf12 %h want 1 0 %h 0 0",
               wbu_ready, wbu_valid, wbu_npc, rs1_data, rs2_data, RESET_PC);
    end
`ifdef WBU_COMMIT_CNT_EN
    n_tests++;
    if (commit_cnt !== 64'd0) begin
      n_fail++;
      $display("FAIL rstmid_commit_cnt: got %0d want 0", commit_cnt);
    end
`endif
    rst = 1'b0;
    sb.delete();
    for (int i = 0; i < 32; i++) mdl_rf[i] = '0;
    mdl_cnt = '0;
    @(negedge clk);
  endtask

  task automatic test_halt();
    bit   ok;
    exp_t e;
    int   bad;
    do_reset();
    ifu_ready = 1'b1;
    send(mk(32'hDEAD_BEEF, 32'h0, 32'h8000_0300, 5'd10, 1'b1, 1'b0, 1'b0), ok);
    wait_valid(5, ok);
    n_tests++;
    if (!ok || sb.size() == 0) begin
      n_fail++;
      $display("FAIL halt_preload: valid seen %0d, pending %0d", ok, sb.size());
      return;
    end
    e = sb.pop_front();
    $display("[TB] commit rd=%0d npc=%h before halt", e.rd, wbu_npc);
    @(negedge clk);
    send(mk(32'h0, 32'h0, 32'h8000_0304, 5'd10, 1'b1, 1'b0, 1'b1), ok);
    n_tests++;
    if (!ok || wbu_valid !== 1'b0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_in_write: ok %0d valid %b halted %b want 1 0 0", ok, wbu_valid, halted);
    end
    @(negedge clk);
    rs1_addr = 5'd10;
    #1;
    n_tests++;
    if (halted !== 1'b1 || rs1_data !== mdl_rf[10]) begin
      n_fail++;
      $display("FAIL halt_commit: halted %b rf10 %h want 1 %h", halted, rs1_data, mdl_rf[10]);
    end
    $display("[TB] halt committed rd=10 data=%h", rs1_data);
    bad = 0;
    lsu_valid = 1'b1;
    lsu_data  = mk(32'h5555_5555, 32'h0, 32'h8000_0F00, 5'd11, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (wbu_valid !== 1'b0 || wbu_ready !== 1'b0 || halted !== 1'b1) bad++;
      @(negedge clk);
    end
    lsu_valid = 1'b0;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL halt_hold: %0d of 20 cycles left the halted state, want 0", bad);
    end
    rs2_addr = 5'd11;
    #1;
    n_tests++;
    if (rs2_data !== mdl_rf[11] || wbu_npc !== e.npc + 32'h0 && wbu_npc !== 32'h8000_0304) begin
      n_fail++;
      $display("FAIL halt_ignore: rf11 %h npc %h want %h 80000304", rs2_data, wbu_npc, mdl_rf[11]);
    end
`ifdef WBU_COMMIT_CNT_EN
    n_tests++;
    if (commit_cnt !== mdl_cnt) begin
      n_fail++;
      $display("FAIL halt_commit_cnt: got %0d want %0d", commit_cnt, mdl_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_alu_wb();
    test_load_x0();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
